wb_slave_mux: RTL and testbench

Downstream Wishbone stage that consumes the registered master-side request produced by the interconnect's holding-register stage and routes it to one of four slaves. It decodes a 2-bit slave index from the address, drives a one-hot strobe to the selected slave, and returns that slave's ack/err/data as registered one-cycle pulses. A per-transaction timeout counter turns hung accesses into error responses. Accesses to disabled slaves are also answered with an error.

---
 rtl/wb_slave_mux.sv | 163 ++++++++++++++++
 tb/tb_wb_slave_mux.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_slave_mux.sv
// Wishbone slave mux: routes one registered master request to one of four
// slaves and returns registered ack/err/data pulses, with a per-access timeout.
module wb_slave_mux #(
    parameter int unsigned ADR_LSB = 10,
    parameter logic [3:0]  SLV_EN  = 4'b1111,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk_i,
    input  logic         rst_n,
    input  logic [31:0]  m_dat_i,
    input  logic [31:0]  m_adr_i,
    input  logic [3:0]   m_sel_i,
    input  logic         m_we_i,
    input  logic         m_cyc_i,
    input  logic         m_stb_i,
    output logic [31:0]  m_dat_o,
    output logic         m_ack_o,
    output logic         m_err_o,
    output logic [31:0]  sl_dat_o,
    output logic [31:0]  sl_adr_o,
    output logic [3:0]   sl_sel_o,
    output logic         sl_we_o,
    output logic [3:0]   sl_cyc_o,
    output logic [3:0]   sl_stb_o,
    input  logic [127:0] sl_dat_i,
    input  logic [3:0]   sl_ack_i,
    input  logic [3:0]   sl_err_i
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [7:0] TO = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] m_dat_q, m_dat_d;
    logic        m_ack_q, m_ack_d;
    logic        m_err_q, m_err_d;
    logic [31:0] sl_dat_q, sl_dat_d;
    logic [31:0] sl_adr_q, sl_adr_d;
    logic [3:0]  sl_sel_q, sl_sel_d;
    logic        sl_we_q, sl_we_d;
    logic [3:0]  sl_cyc_q, sl_cyc_d;
    logic [3:0]  sl_stb_q, sl_stb_d;

    logic [1:0]  req_idx;
    logic        sel_ack;
    logic        sel_err;
    logic [31:0] sel_dat;

    assign req_idx = m_adr_i[ADR_LSB+1:ADR_LSB];
    // Only the latched slave is listened to; all others are ignored.
    assign sel_ack = sl_ack_i[idx_q];
    assign sel_err = sl_err_i[idx_q];
    assign sel_dat = sl_dat_i[32*idx_q +: 32];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        m_dat_d  = m_dat_q;
        m_ack_d  = 1'b0;
        m_err_d  = 1'b0;
        sl_dat_d = sl_dat_q;
        sl_adr_d = sl_adr_q;
        sl_sel_d = sl_sel_q;
        sl_we_d  = sl_we_q;
        sl_cyc_d = sl_cyc_q;
        sl_stb_d = sl_stb_q;
        unique case (state_q)
            IDLE: begin
                if (m_cyc_i && m_stb_i) begin
                    sl_adr_d = m_adr_i;
                    sl_dat_d = m_dat_i;
                    sl_sel_d = m_sel_i;
                    sl_we_d  = m_we_i;
                    idx_d    = req_idx;
                    if (SLV_EN[req_idx]) begin
                        sl_cyc_d = 4'b0001 << req_idx;
                        sl_stb_d = 4'b0001 << req_idx;
                        cnt_d    = 8'd0;
                        state_d  = WAIT;
                    end else begin
                        m_err_d = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (sel_ack || sel_err) begin
                    m_ack_d  = sel_ack;
                    m_err_d  = sel_err & ~sel_ack;
                    if (sel_ack && !sl_we_q) begin
                        m_dat_d = sel_dat;
                    end
                    sl_cyc_d = 4'b0000;
                    sl_stb_d = 4'b0000;
                    state_d  = RESP;
                end else if (!m_cyc_i) begin
                    sl_cyc_d = 4'b0000;
                    sl_stb_d = 4'b0000;
                    state_d  = IDLE;
                end else if (cnt_q == TO) begin
                    m_err_d  = 1'b1;
                    sl_cyc_d = 4'b0000;
                    sl_stb_d = 4'b0000;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            // One dead cycle lets upstream drop its strobe before re-arming.
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            idx_q    <= 2'd0;
            m_dat_q  <= 32'd0;
            m_ack_q  <= 1'b0;
            m_err_q  <= 1'b0;
            sl_dat_q <= 32'd0;
            sl_adr_q <= 32'd0;
            sl_sel_q <= 4'd0;
            sl_we_q  <= 1'b0;
            sl_cyc_q <= 4'd0;
            sl_stb_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            m_dat_q  <= m_dat_d;
            m_ack_q  <= m_ack_d;
            m_err_q  <= m_err_d;
            sl_dat_q <= sl_dat_d;
            sl_adr_q <= sl_adr_d;
            sl_sel_q <= sl_sel_d;
            sl_we_q  <= sl_we_d;
            sl_cyc_q <= sl_cyc_d;
            sl_stb_q <= sl_stb_d;
        end
    end

    assign m_dat_o  = m_dat_q;
    assign m_ack_o  = m_ack_q;
    assign m_err_o  = m_err_q;
    assign sl_dat_o = sl_dat_q;
    assign sl_adr_o = sl_adr_q;
    assign sl_sel_o = sl_sel_q;
    assign sl_we_o  = sl_we_q;
    assign sl_cyc_o = sl_cyc_q;
    assign sl_stb_o = sl_stb_q;

endmodule

// File: tb/tb_wb_slave_mux.sv
// Self-checking bench for wb_slave_mux: directed scenarios plus random
// transactions scored against a transaction-level outcome model.
module tb_wb_slave_mux;

    localparam logic [3:0] EN = 4'b0111;
    localparam int         TO = 8;

    logic         clk_i = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  m_dat_i = '0;
    logic [31:0]  m_adr_i = '0;
    logic [3:0]   m_sel_i = '0;
    logic         m_we_i = 1'b0;
    logic         m_cyc_i = 1'b0;
    logic         m_stb_i = 1'b0;
    logic [31:0]  m_dat_o;
    logic         m_ack_o;
    logic         m_err_o;
    logic [31:0]  sl_dat_o;
    logic [31:0]  sl_adr_o;
    logic [3:0]   sl_sel_o;
    logic         sl_we_o;
    logic [3:0]   sl_cyc_o;
    logic [3:0]   sl_stb_o;
    logic [127:0] sl_dat_i = '0;
    logic [3:0]   sl_ack_i = '0;
    logic [3:0]   sl_err_i = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Transaction observations filled by drive_txn
    int          o_first, o_rsp, o_nstb;
    logic        o_ack, o_err, o_bad, o_both;
    logic [3:0]  o_stb_at_rsp;
    logic [31:0] model_dat;

    wb_slave_mux #(
        .ADR_LSB(10),
        .SLV_EN (EN),
        .TIMEOUT(TO)
    ) dut (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .m_dat_i (m_dat_i),
        .m_adr_i (m_adr_i),
        .m_sel_i (m_sel_i),
        .m_we_i  (m_we_i),
        .m_cyc_i (m_cyc_i),
        .m_stb_i (m_stb_i),
        .m_dat_o (m_dat_o),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .sl_dat_o(sl_dat_o),
        .sl_adr_o(sl_adr_o),
        .sl_sel_o(sl_sel_o),
        .sl_we_o (sl_we_o),
        .sl_cyc_o(sl_cyc_o),
        .sl_stb_o(sl_stb_o),
        .sl_dat_i(sl_dat_i),
        .sl_ack_i(sl_ack_i),
        .sl_err_i(sl_err_i)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Master + slave driver. Called at a negedge; offsets are cycles since call.
    // The selected slave responds on the rsp_j-th strobe cycle; others babble.
    task automatic drive_txn(input logic [31:0] adr, input logic [31:0] dat,
                             input logic we, input logic [3:0] sel,
                             input int rsp_j, input bit rsp_err,
                             input logic [31:0] rdata, input bit hold,
                             input int abort_at);
        int start;
        logic [1:0] idx;
        logic [3:0] mask;
        idx = adr[11:10];
        mask = 4'b0001 << idx;
        m_adr_i = adr; m_dat_i = dat; m_we_i = we; m_sel_i = sel;
        m_cyc_i = 1'b1; m_stb_i = 1'b1;
        start = cyc;
        o_first = -1; o_rsp = -1; o_nstb = 0;
        o_ack = 0; o_err = 0; o_bad = 0; o_both = 0; o_stb_at_rsp = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_i);
            sl_ack_i = 4'($urandom) & ~mask;
            sl_err_i = 4'($urandom) & ~mask;
            sl_dat_i = {$urandom, $urandom, $urandom, $urandom};
            if (m_ack_o && m_err_o) o_both = 1;
            if (m_ack_o || m_err_o) begin
                o_rsp = cyc - start;
                o_ack = m_ack_o;
                o_err = m_err_o;
                o_stb_at_rsp = sl_stb_o;
                if (!hold) begin
                    m_cyc_i = 1'b0; m_stb_i = 1'b0;
                end
                break;
            end
            if (sl_stb_o != 4'b0000) begin
                if (o_first < 0) o_first = cyc - start;
                o_nstb++;
                if (sl_stb_o != mask || sl_cyc_o != mask) o_bad = 1;
                if (o_nstb == rsp_j) begin
                    if (rsp_err) sl_err_i[idx] = 1'b1;
                    else sl_ack_i[idx] = 1'b1;
                    sl_dat_i[32*idx +: 32] = rdata;
                end
            end
            if (k == abort_at) begin
                m_cyc_i = 1'b0; m_stb_i = 1'b0;
            end
        end
        sl_ack_i = '0;
        sl_err_i = '0;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        checks++;
        if ({m_ack_o, m_err_o, m_dat_o} !== 34'd0) begin
            errors++;
            $display("FAIL reset_master: got %h want 0", {m_ack_o, m_err_o, m_dat_o});
        end
        checks++;
        if ({sl_cyc_o, sl_stb_o, sl_adr_o, sl_dat_o, sl_sel_o, sl_we_o} !== 77'd0) begin
            errors++;
            $display("FAIL reset_slave: cyc=%b stb=%b adr=%h dat=%h sel=%h we=%b want all 0",
                     sl_cyc_o, sl_stb_o, sl_adr_o, sl_dat_o, sl_sel_o, sl_we_o);
        end
        model_dat = 32'd0;
    endtask

    task automatic test_read();
        @(negedge clk_i);
        drive_txn(32'h0000_0800, 32'h0, 1'b0, 4'hF, 3, 0, 32'hDEAD_BEEF, 0, 0);
        model_dat = 32'hDEAD_BEEF;
        checks++;
        if ({o_first, o_nstb, o_rsp - o_first} !== {32'd1, 32'd3, 32'd3}) begin
            errors++;
            $display("FAIL read_timing: first=%0d nstb=%0d lat=%0d want 1 3 3",
                     o_first, o_nstb, o_rsp - o_first);
        end
        checks++;
        if ({o_ack, o_err, o_bad, o_stb_at_rsp} !== 7'b1000000) begin
            errors++;
            $display("FAIL read_resp: ack=%b err=%b bad=%b stb=%b want 1 0 0 0000",
                     o_ack, o_err, o_bad, o_stb_at_rsp);
        end
        checks++;
        if (m_dat_o !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL read_data: got %h want deadbeef", m_dat_o);
        end
    endtask

    task automatic test_write();
        @(negedge clk_i);
        drive_txn(32'h0000_0400, 32'h1234_5678, 1'b1, 4'hF, 1, 0, 32'hCAFE_F00D, 0, 0);
        checks++;
        if ({sl_adr_o, sl_dat_o, sl_sel_o, sl_we_o} !== {32'h400, 32'h1234_5678, 4'hF, 1'b1}) begin
            errors++;
            $display("FAIL write_fields: adr=%h dat=%h sel=%h we=%b want 400 12345678 f 1",
                     sl_adr_o, sl_dat_o, sl_sel_o, sl_we_o);
        end
        checks++;
        if ({o_ack, o_err, o_nstb} !== {1'b1, 1'b0, 32'd1}) begin
            errors++;
            $display("FAIL write_resp: ack=%b err=%b nstb=%0d want 1 0 1", o_ack, o_err, o_nstb);
        end
        checks++;
        if (m_dat_o !== model_dat) begin
            errors++;
            $display("FAIL write_keeps_dat: got %h want %h", m_dat_o, model_dat);
        end
    endtask

    task automatic test_timeout();
        @(negedge clk_i);
        drive_txn(32'h0000_0010, 32'h0, 1'b0, 4'hF, 1000, 0, 32'h0, 0, 0);
        checks++;
        if ({o_rsp, o_nstb} !== {32'(TO + 2), 32'(TO + 1)}) begin
            errors++;
            $display("FAIL timeout_timing: rsp=%0d nstb=%0d want %0d %0d",
                     o_rsp, o_nstb, TO + 2, TO + 1);
        end
        checks++;
        if ({o_ack, o_err, o_stb_at_rsp} !== 6'b010000) begin
            errors++;
            $display("FAIL timeout_resp: ack=%b err=%b stb=%b want 0 1 0000",
                     o_ack, o_err, o_stb_at_rsp);
        end
    endtask

    task automatic test_race();
        @(negedge clk_i);
        drive_txn(32'h0000_0400, 32'h0, 1'b0, 4'h3, TO + 1, 0, 32'h5A5A_0001, 0, 0);
        model_dat = 32'h5A5A_0001;
        checks++;
        if ({o_ack, o_err, o_rsp - o_first, m_dat_o} !== {1'b1, 1'b0, 32'(TO + 1), 32'h5A5A_0001}) begin
            errors++;
            $display("FAIL race_resp_wins: ack=%b err=%b lat=%0d dat=%h want 1 0 %0d 5a5a0001",
                     o_ack, o_err, o_rsp - o_first, m_dat_o, TO + 1);
        end
    endtask

    task automatic test_slave_err();
        @(negedge clk_i);
        drive_txn(32'h0000_0000, 32'h0, 1'b0, 4'hF, 2, 1, 32'h1111_2222, 0, 0);
        checks++;
        if ({o_ack, o_err, o_rsp - o_first, m_dat_o} !== {1'b0, 1'b1, 32'd2, model_dat}) begin
            errors++;
            $display("FAIL slave_err: ack=%b err=%b lat=%0d dat=%h want 0 1 2 %h",
                     o_ack, o_err, o_rsp - o_first, m_dat_o, model_dat);
        end
    endtask

    task automatic test_disabled();
        @(negedge clk_i);
        drive_txn(32'h0000_0C00, 32'h0, 1'b0, 4'hF, 1, 0, 32'h0, 0, 0);
        checks++;
        if ({o_rsp, o_nstb, o_ack, o_err} !== {32'd1, 32'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL disabled: rsp=%0d nstb=%0d ack=%b err=%b want 1 0 0 1",
                     o_rsp, o_nstb, o_ack, o_err);
        end
    endtask

    task automatic test_abort();
        @(negedge clk_i);
        drive_txn(32'h0000_0800, 32'h0, 1'b0, 4'hF, 1000, 0, 32'h0, 0, 3);
        checks++;
        if ({o_rsp, o_nstb, o_bad} !== {-32'sd1, 32'd3, 1'b0}) begin
            errors++;
            $display("FAIL abort: rsp=%0d nstb=%0d bad=%b want -1 3 0", o_rsp, o_nstb, o_bad);
        end
        @(negedge clk_i);
        drive_txn(32'h0000_0800, 32'h0, 1'b0, 4'hF, 2, 0, 32'h0BAD_CAFE, 0, 0);
        model_dat = 32'h0BAD_CAFE;
        checks++;
        if ({o_first, o_ack, m_dat_o} !== {32'd1, 1'b1, 32'h0BAD_CAFE}) begin
            errors++;
            $display("FAIL abort_recover: first=%0d ack=%b dat=%h want 1 1 0badcafe",
                     o_first, o_ack, m_dat_o);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk_i);
        m_adr_i = 32'h0000_0400; m_we_i = 1'b1; m_dat_i = 32'hFFFF_0000;
        m_sel_i = 4'hC; m_cyc_i = 1'b1; m_stb_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m_ack_o, m_err_o, m_dat_o, sl_cyc_o, sl_stb_o, sl_adr_o, sl_dat_o, sl_sel_o, sl_we_o} !== 111'd0) begin
            errors++;
            $display("FAIL reset_mid: stb=%b adr=%h dat=%h mdat=%h want all 0",
                     sl_stb_o, sl_adr_o, sl_dat_o, m_dat_o);
        end
        model_dat = 32'd0;
        @(negedge clk_i);
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        rst_n = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({m_ack_o, m_err_o, sl_stb_o} !== 6'd0) begin
            errors++;
            $display("FAIL reset_mid_idle: ack=%b err=%b stb=%b want 0", m_ack_o, m_err_o, sl_stb_o);
        end
    endtask

    task automatic test_back_to_back();
        int n1;
        @(negedge clk_i);
        drive_txn(32'h0000_0004, 32'h0, 1'b0, 4'hF, 2, 0, 32'h7777_8888, 1, 0);
        n1 = o_nstb;
        model_dat = 32'h7777_8888;
        drive_txn(32'h0000_0808, 32'hABCD_0000, 1'b1, 4'h1, 1, 0, 32'h0, 0, 0);
        checks++;
        if (n1 !== 2) begin
            errors++;
            $display("FAIL b2b_first_strobes: got %0d want 2", n1);
        end
        checks++;
        if ({o_first, o_nstb, o_ack, o_bad} !== {32'd2, 32'd1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL b2b_second: first=%0d nstb=%0d ack=%b bad=%b want 2 1 1 0",
                     o_first, o_nstb, o_ack, o_bad);
        end
    endtask

    task automatic test_random();
        logic [31:0] adr, dat, rd;
        logic [1:0]  idx;
        logic        we, re, e_ack, e_err;
        int          j, e_n, e_off, off;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            idx = 2'($urandom_range(0, 3));
            adr = $urandom;
            adr[11:10] = idx;
            dat = $urandom;
            rd  = $urandom;
            we  = 1'($urandom_range(0, 1));
            re  = ($urandom_range(0, 3) == 0);
            j   = $urandom_range(1, 12);
            drive_txn(adr, dat, we, 4'($urandom), j, re, rd, 0, 0);
            if (!EN[idx]) begin
                e_ack = 0; e_err = 1; e_n = 0; e_off = 1;
            end else if (j <= TO + 1) begin
                e_ack = !re; e_err = re; e_n = j; e_off = j;
            end else begin
                e_ack = 0; e_err = 1; e_n = TO + 1; e_off = TO + 1;
            end
            if (e_ack && !we) model_dat = rd;
            off = EN[idx] ? o_rsp - o_first : o_rsp;
            checks++;
            if ({o_ack, o_err, o_nstb, off, o_bad, o_both} !== {e_ack, e_err, e_n, e_off, 2'b00}) begin
                errors++;
                $display("FAIL rand_%0d: ack=%b err=%b nstb=%0d off=%0d bad=%b both=%b want %b %b %0d %0d 0 0",
                         i, o_ack, o_err, o_nstb, off, o_bad, o_both, e_ack, e_err, e_n, e_off);
            end
            checks++;
            if ({m_dat_o, sl_adr_o, sl_dat_o, sl_we_o} !== {model_dat, adr, dat, we}) begin
                errors++;
                $display("FAIL rand_data_%0d: mdat=%h adr=%h dat=%h we=%b want %h %h %h %b",
                         i, m_dat_o, sl_adr_o, sl_dat_o, sl_we_o, model_dat, adr, dat, we);
            end
        end
    endtask

    initial begin
        model_dat = '0;
        repeat (3) @(negedge clk_i);
        rst_n = 1'b1;
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_race();
        test_slave_err();
        test_disabled();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
